// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_IC    = 2'd0,
    SRC_DC_RD = 2'd1,
    SRC_DC_WR = 2'd2
  } arb_src_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Any data-cache grant sets the fairness flag that favours the icache next.
  function automatic logic src_is_dc(input arb_src_e src);
    return (src != SRC_IC);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority_select.sv
// Combinational winner selection among the three memory requesters.
module arb_priority_select
  import mem_port_arbiter_pkg::*;
(
  input  logic     i_ic_req,
  input  logic     i_dc_rd_req,
  input  logic     i_dc_wr_req,
  input  logic     i_last_was_dc,
  output logic     o_any_req,
  output arb_src_e o_src
);

  assign o_any_req = i_ic_req | i_dc_rd_req | i_dc_wr_req;

  // Fixed priority write > read > ifetch, overridden for the icache right after a dc grant
  always_comb begin
    o_src = SRC_IC;
    if (i_last_was_dc && i_ic_req) begin
      o_src = SRC_IC;
    end else if (i_dc_wr_req) begin
      o_src = SRC_DC_WR;
    end else if (i_dc_rd_req) begin
      o_src = SRC_DC_RD;
    end else begin
      o_src = SRC_IC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction-cache reads and
// data-cache reads/write-backs; one transaction in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [WIDTH-1:0]  ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [WIDTH-1:0]  dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [WIDTH-1:0]  dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data_out,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_data_in
);

  arb_state_e        r_state;
  arb_src_e          r_src;
  logic              r_last_was_dc;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic              r_ic_ack;
  logic              r_dc_rd_ack;
  logic              r_dc_wr_ack;
  logic [WIDTH-1:0]  r_ic_data;
  logic [WIDTH-1:0]  r_dc_data;

  logic              w_any_req;
  arb_src_e          w_win_src;
  logic [ADDR_W-1:0] w_win_addr;

  arb_priority_select u_sel (
    .i_ic_req      (ic_read_req),
    .i_dc_rd_req   (dc_read_req),
    .i_dc_wr_req   (dc_write_req),
    .i_last_was_dc (r_last_was_dc),
    .o_any_req     (w_any_req),
    .o_src         (w_win_src)
  );

  // Address of the request the selector picked this cycle
  always_comb begin
    w_win_addr = ic_read_addr;
    case (w_win_src)
      SRC_DC_RD: w_win_addr = dc_read_addr;
      SRC_DC_WR: w_win_addr = dc_write_addr;
      default:   w_win_addr = ic_read_addr;
    endcase
  end

  // Grant, memory handshake, one-cycle response and a release cycle before re-arbitrating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_src         <= SRC_IC;
      r_last_was_dc <= 1'b0;
      r_mem_enable  <= 1'b0;
      r_mem_rw      <= MEM_READ;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_ic_ack      <= 1'b0;
      r_dc_rd_ack   <= 1'b0;
      r_dc_wr_ack   <= 1'b0;
      r_ic_data     <= '0;
      r_dc_data     <= '0;
    end else begin
      r_ic_ack    <= 1'b0;
      r_dc_rd_ack <= 1'b0;
      r_dc_wr_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_src         <= w_win_src;
            r_mem_addr    <= w_win_addr;
            r_mem_rw      <= (w_win_src == SRC_DC_WR) ? MEM_WRITE : MEM_READ;
            if (w_win_src == SRC_DC_WR) begin
              r_mem_wdata <= dc_write_data;
            end
            r_last_was_dc <= src_is_dc(w_win_src);
            r_mem_enable  <= 1'b1;
            r_state       <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Requesters may have dropped req by now; the transaction still completes.
          if (mem_ack) begin
            r_mem_enable <= 1'b0;
            case (r_src)
              SRC_DC_RD: begin
                r_dc_data   <= mem_data_in;
                r_dc_rd_ack <= 1'b1;
              end
              SRC_DC_WR: r_dc_wr_ack <= 1'b1;
              default: begin
                r_ic_data <= mem_data_in;
                r_ic_ack  <= 1'b1;
              end
            endcase
            r_state <= ST_RESP;
          end
        end
        ST_RESP:    r_state <= ST_RELEASE;
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_enable   = r_mem_enable;
  assign mem_rw       = r_mem_rw;
  assign mem_addr     = r_mem_addr;
  assign mem_data_out = r_mem_wdata;
  assign ic_read_ack  = r_ic_ack;
  assign dc_read_ack  = r_dc_rd_ack;
  assign dc_write_ack = r_dc_wr_ack;
  assign ic_read_data = r_ic_data;
  assign dc_read_data = r_dc_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses,
// a negedge monitor pops and compares on every ack and every new grant.
module tb_mem_port_arbiter;

  localparam int W  = 128;
  localparam int A  = 32;
  localparam int IC = 0;
  localparam int DR = 1;
  localparam int DW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_v [3];
  logic [A-1:0] addr_v [3];
  logic [W-1:0] w_data;
  logic         ic_read_ack, dc_read_ack, dc_write_ack;
  logic [W-1:0] ic_read_data, dc_read_data;
  logic         mem_enable, mem_rw;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data_out;
  logic         mem_ack;
  logic [W-1:0] mem_data_in;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .ADDR_W(A)) dut (
    .clk          (clk),
    .reset        (reset),
    .ic_read_req  (req_v[IC]),
    .ic_read_addr (addr_v[IC]),
    .ic_read_ack  (ic_read_ack),
    .ic_read_data (ic_read_data),
    .dc_read_req  (req_v[DR]),
    .dc_read_addr (addr_v[DR]),
    .dc_read_ack  (dc_read_ack),
    .dc_read_data (dc_read_data),
    .dc_write_req (req_v[DW]),
    .dc_write_addr(addr_v[DW]),
    .dc_write_data(w_data),
    .dc_write_ack (dc_write_ack),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_ack      (mem_ack),
    .mem_data_in  (mem_data_in)
  );

  // Memory contents seen by reads: a fixed function of the address.
  function automatic logic [W-1:0] line_of(input logic [A-1:0] a);
    return {32'hDEADBEEF, a, ~a, a ^ 32'h1357_9BDF};
  endfunction

  // Reference arbitration rule.
  function automatic int pick(input logic [2:0] r, input logic ldc);
    if (ldc && r[IC]) return IC;
    if (r[DW]) return DW;
    if (r[DR]) return DR;
    if (r[IC]) return IC;
    return -1;
  endfunction

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Scoreboard queues (one per source) and handshakes between processes.
  logic [W-1:0] q_ic [$];
  logic [W-1:0] q_dr [$];
  logic [W-1:0] q_dw [$];
  int ack_cnt [3];
  int done_cnt [3];
  int auto_re [3];
  int fixed_lat = 3;
  int spur_req = 0;
  int spur_done = 0;
  int timeouts = 0;
  int to_seen = 0;
  int async_cnt = 0;
  int async_seen = 0;
  logic async_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks after a per-transaction latency, can inject a stray ack.
  initial begin : mem_model
    int en_cyc;
    int cur_lat;
    en_cyc = 0;
    cur_lat = 1;
    mem_ack = 1'b0;
    mem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset || !mem_enable) begin
        en_cyc = 0;
        if (reset && spur_req != spur_done) begin
          spur_done = spur_req;
          mem_ack = 1'b1;
          mem_data_in = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        if (en_cyc == 0) cur_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        en_cyc++;
        if (en_cyc == cur_lat) begin
          mem_ack = 1'b1;
          mem_data_in = mem_rw ? {$urandom, $urandom, $urandom, $urandom} : line_of(mem_addr);
        end
      end
    end
  end

  // Monitor state
  logic [2:0]   prev_req = '0;
  logic         prev_en = 1'b0;
  logic         model_ldc = 1'b0;
  logic         model_busy = 1'b0;
  logic         expect_grant = 1'b0;
  logic         mack_seen = 1'b0;
  int           last_mack = 0;
  int           rel_cycle = 0;
  int           grant_src = -1;
  logic [A-1:0] g_addr = '0;
  logic         g_rw = 1'b0;
  logic [W-1:0] g_data = '0;
  logic [W-1:0] hold_ic = '0;
  logic [W-1:0] hold_dc = '0;

  always @(negedge clk) begin : monitor
    logic [2:0] cur;
    logic [2:0] ackb;
    int w;
    int nacks;
    int qs;
    logic [W-1:0] e;
    cur = {req_v[DW], req_v[DR], req_v[IC]};
    ackb = {dc_write_ack, dc_read_ack, ic_read_ack};
    nacks = int'(ackb[0]) + int'(ackb[1]) + int'(ackb[2]);
    if (async_cnt != async_seen) begin
      async_seen = async_cnt;
      chk_i("async_reset_enable", int'(async_en), 0);
    end
    if (timeouts != to_seen) begin
      chk_i("wait_bound", timeouts - to_seen, 0);
      to_seen = timeouts;
    end
    if (!reset) begin
      chk_i("rst_enable", int'(mem_enable), 0);
      chk_i("rst_acks", int'(ackb), 0);
      chk_i("rst_rw", int'(mem_rw), 0);
      chk_w("rst_addr", W'(mem_addr), '0);
      chk_w("rst_wdata", mem_data_out, '0);
      chk_w("rst_ic_data", ic_read_data, '0);
      chk_w("rst_dc_data", dc_read_data, '0);
      model_ldc = 1'b0; model_busy = 1'b0; expect_grant = 1'b0; mack_seen = 1'b0;
      rel_cycle = 0; grant_src = -1; hold_ic = '0; hold_dc = '0;
      prev_req = '0; prev_en = 1'b0;
    end else begin
      if (expect_grant) chk_i("grant_latency", int'(mem_enable && !prev_en), 1);
      if (mem_enable && !prev_en) begin
        w = pick(prev_req, model_ldc);
        chk_i("grant_spacing", int'(!model_busy && cyc >= rel_cycle + 1), 1);
        chk_i("grant_has_req", int'(w >= 0), 1);
        if (w >= 0) begin
          chk_i("grant_rw", int'(mem_rw), int'(w == DW));
          chk_w("grant_addr", W'(mem_addr), W'(addr_v[w]));
          if (w == DW) chk_w("grant_wdata", mem_data_out, w_data);
          model_ldc = (w != IC);
        end
        grant_src = w; g_addr = mem_addr; g_rw = mem_rw; g_data = mem_data_out;
        model_busy = 1'b1;
      end else if (mem_enable && prev_en) begin
        chk_w("busy_addr_stable", W'(mem_addr), W'(g_addr));
        chk_i("busy_rw_stable", int'(mem_rw), int'(g_rw));
        if (g_rw) chk_w("busy_wdata_stable", mem_data_out, g_data);
      end
      if (mem_enable && mem_ack) begin
        mack_seen = 1'b1;
        last_mack = cyc;
      end
      if (mack_seen && cyc == last_mack + 1) chk_i("ack_after_mem_ack", nacks, 1);
      else if (nacks != 0) chk_i("ack_without_mem_ack", nacks, 0);
      if (nacks != 0) begin
        chk_i("ack_enable_low", int'(mem_enable), 0);
        for (int s = 0; s < 3; s++) begin
          if (ackb[s]) begin
            chk_i("ack_source", s, grant_src);
            qs = (s == IC) ? q_ic.size() : (s == DR) ? q_dr.size() : q_dw.size();
            chk_i("ack_expected", int'(qs != 0), 1);
            if (qs != 0) begin
              case (s)
                IC: e = q_ic.pop_front();
                DR: e = q_dr.pop_front();
                default: e = q_dw.pop_front();
              endcase
              if (s == IC) begin chk_w("ic_read_data", ic_read_data, e); hold_ic = e; end
              if (s == DR) begin chk_w("dc_read_data", dc_read_data, e); hold_dc = e; end
              $display("txn cyc=%0d src=%0d addr=%h line=%h", cyc, s, g_addr, e);
            end
            ack_cnt[s]++;
          end
        end
        grant_src = -1; mack_seen = 1'b0; model_busy = 1'b0; rel_cycle = cyc + 2;
      end
      chk_w("ic_data_hold", ic_read_data, hold_ic);
      chk_w("dc_data_hold", dc_read_data, hold_dc);
      expect_grant = (cur != 3'b000) && !model_busy && (cyc >= rel_cycle);
      prev_req = cur;
      prev_en = mem_enable;
    end
  end

  // Raise a request and record what the scoreboard must see for it.
  task automatic issue(input int s, input logic [A-1:0] a, input logic [W-1:0] d);
    addr_v[s] = a;
    req_v[s] = 1'b1;
    case (s)
      IC: q_ic.push_back(line_of(a));
      DR: q_dr.push_back(line_of(a));
      default: begin w_data = d; q_dw.push_back(d); end
    endcase
  endtask

  // Advance one cycle; requesters drop (or re-issue) after their ack.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      if (ack_cnt[s] != done_cnt[s]) begin
        done_cnt[s] = ack_cnt[s];
        if (auto_re[s] != 0) issue(s, $urandom, {$urandom, $urandom, $urandom, $urandom});
        else req_v[s] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_ic.size() + q_dr.size() + q_dw.size() != 0 || req_v[IC] || req_v[DR] || req_v[DW]) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) timeouts++;
    tick(); tick(); tick();
  endtask

  task automatic wait_enable();
    int n;
    n = 0;
    while (!mem_enable && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) timeouts++;
  endtask

  initial begin : stim
    for (int s = 0; s < 3; s++) begin
      req_v[s] = 1'b0; addr_v[s] = '0; ack_cnt[s] = 0; done_cnt[s] = 0; auto_re[s] = 0;
    end
    w_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Lone ifetch, memory answers three cycles into the transaction.
    fixed_lat = 3;
    issue(IC, 32'h0000_0040, '0);
    wait_idle();

    // Write-back and ifetch together: write first, then the ifetch.
    fixed_lat = 2;
    issue(DW, 32'h0000_0800, {$urandom, $urandom, $urandom, $urandom});
    issue(IC, 32'h0000_0C40, '0);
    wait_idle();

    // Data read held continuously alongside ifetch: grants alternate, back-to-back.
    fixed_lat = 0;
    auto_re[DR] = 1; auto_re[IC] = 1;
    issue(DR, $urandom, '0);
    issue(IC, $urandom, '0);
    repeat (60) tick();
    auto_re[DR] = 0; auto_re[IC] = 0;
    wait_idle();

    // Request dropped after grant still completes and acks.
    fixed_lat = 3;
    issue(IC, 32'h0000_2000, '0);
    wait_enable();
    req_v[IC] = 1'b0;
    wait_idle();

    // Reset in the middle of a data read; the held request is reissued afterwards.
    fixed_lat = 6;
    issue(DR, 32'h0000_0100, '0);
    wait_enable();
    tick();
    #3;
    reset = 1'b0;
    #1;
    async_en = mem_enable;
    async_cnt++;
    tick();
    tick();
    reset = 1'b1;
    fixed_lat = 3;
    wait_idle();

    // Stray memory ack while idle, then a normal read.
    spur_req++;
    tick(); tick(); tick();
    fixed_lat = 2;
    issue(DR, 32'h0000_0300, '0);
    wait_idle();

    // Random traffic with random memory latency.
    fixed_lat = 0;
    repeat (1500) begin
      tick();
      for (int s = 0; s < 3; s++) begin
        if (!req_v[s] && $urandom_range(0, 2) == 0)
          issue(s, $urandom, {$urandom, $urandom, $urandom, $urandom});
      end
    end
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
